wptr_handler: RTL and testbench
===============================

// Module: wptr_handler
// PURPOSE
//  Write-domain pointer/flag stage of the async FIFO; sits directly upstream of fifo_mem.
//  Keeps the binary write pointer (b_wptr, drives fifo_mem write address) and its Gray copy (g_wptr, crosses to read domain).
//  Compares against the read-domain Gray pointer to produce full, almost_full, fill level and a sticky overflow flag.
// PARAMETERS
//  PTR_WIDTH  3  address bits; pointers are PTR_WIDTH+1 bits (MSB = wrap bit)
//  DEPTH      8  FIFO entries; must equal 2**PTR_WIDTH
//  AF_LEVEL   6  almost_full asserts when fill level >= AF_LEVEL (1..DEPTH)
// PORTS
//  wclk         in   1            write clock; all state on posedge
//  wrst         in   1            synchronous reset, active-high
//  w_en         in   1            write request (same signal fifo_mem sees)
//  g_rptr       in   PTR_WIDTH+1  read pointer, Gray coded (see CONFIGURATION)
//  clr_ovf      in   1            clear sticky overflow
//  b_wptr       out  PTR_WIDTH+1  binary write pointer, registered
//  g_wptr       out  PTR_WIDTH+1  Gray write pointer, registered, = b_wptr ^ (b_wptr>>1)
//  full         out  1            registered full flag
//  almost_full  out  1            registered, level >= AF_LEVEL
//  wr_level     out  PTR_WIDTH+1  registered fill level, 0..DEPTH
//  overflow     out  1            sticky: write attempted while full
// BEHAVIOUR
//  - Reset (wrst=1 at posedge): b_wptr, g_wptr, wr_level = 0; full, almost_full, overflow = 0. Takes priority over all else, mid-operation included.
//  - Accept: wr_acc = w_en & ~full. b_next = b_wptr + wr_acc (mod 2**(PTR_WIDTH+1), natural wrap); g_next = b_next ^ (b_next>>1).
//  - Pointers: b_wptr <= b_next, g_wptr <= g_next; update same edge as fifo_mem stores data_in.
//  - rs = read pointer used for compares (g_rptr direct or synced copy); rb = Gray-to-binary(rs).
//  - full <= (g_next == {~rs[PTR_WIDTH:PTR_WIDTH-1], rs[PTR_WIDTH-2:0]}).
//  - wr_level <= b_next - rb, truncated to PTR_WIDTH+1 bits (wrap-safe); never exceeds DEPTH.
//  - almost_full <= ((b_next - rb) >= AF_LEVEL).
//  - Flag latency: full/almost_full/wr_level reflect a write one cycle after the accepting edge; a read
//    is seen once rs changes, next edge. Stale rs only overstates level (conservative), never understates.
//  - Write while full (w_en & full): dropped, pointers hold, overflow <= 1 next edge.
//  - overflow: set by w_en & full; cleared by clr_ovf; set and clear same cycle -> stays 1 (set wins).
//  - w_en held continuously: one accept per cycle until full; accept on edge where full goes high is the DEPTH-th write.
//  - Wrap: b_wptr 2**(PTR_WIDTH+1)-1 -> 0; Gray moves one bit per increment (e.g. 4'b1000 -> 4'b0000 at PTR_WIDTH=3).
// CONFIGURATION
//  WPTR_RSYNC_EN defined: g_rptr is raw read-domain pointer; internal 2-flop synchronizer on wclk
//    (both stages reset to 0 by wrst), rs = 2nd stage. Read-side changes reach flags 3 wclk edges after g_rptr changes.
//  WPTR_RSYNC_EN undefined: g_rptr is already synchronized externally; rs = g_rptr, flags update on next edge.
//  Write-side latency identical in both builds.
// TESTING
//  1. wrst=1 two cycles, w_en=1, g_rptr=4'b1111 -> all outputs 0 during/after reset; no write accepted during reset.
//  2. g_rptr=0, w_en=1 for 8 cycles -> b_wptr 1..8, g_wptr(8)=4'b1100, almost_full after 6th write, full and wr_level=8 after 8th.
//  3. From full, w_en=1 one more cycle -> b_wptr stays 8, overflow=1; then w_en=1,clr_ovf=1 -> overflow stays 1; w_en=0,clr_ovf=1 -> 0.
//  4. From full, g_rptr <= 4'b0011 (bin 2) -> full=0, wr_level=6, almost_full=1 after 1 edge (3 edges with WPTR_RSYNC_EN).
//  5. Stream writes/reads (read ptr trailing by 2) for 40 cycles -> b_wptr wraps 15->0, g_wptr 4'b1000->4'b0000, wr_level constant 2, no false full.
//  6. Assert wrst mid-fill at wr_level=5 -> next edge all outputs 0; g_rptr=0 then 8 writes re-reach full exactly.

Source files
------------

// File: rtl/wptr_handler_if.sv
// Signal bundle between the write-side FIFO controller and wptr_handler.
// master: write-side controller (drives request, read pointer, overflow clear)
// slave : wptr_handler (drives pointers and flags)
interface wptr_handler_if #(
    parameter int PTR_WIDTH = 3
);
    logic                 w_en;
    logic [PTR_WIDTH:0]   g_rptr;
    logic                 clr_ovf;
    logic [PTR_WIDTH:0]   b_wptr;
    logic [PTR_WIDTH:0]   g_wptr;
    logic                 full;
    logic                 almost_full;
    logic [PTR_WIDTH:0]   wr_level;
    logic                 overflow;

    modport master (
        output w_en, g_rptr, clr_ovf,
        input  b_wptr, g_wptr, full, almost_full, wr_level, overflow
    );

    modport slave (
        input  w_en, g_rptr, clr_ovf,
        output b_wptr, g_wptr, full, almost_full, wr_level, overflow
    );
endinterface

// File: rtl/wptr_handler.sv
// Write-domain pointer/flag stage of the async FIFO.
// Holds the binary write pointer (fifo_mem address) and its Gray copy (crosses
// to the read domain), and derives full / almost_full / fill level / sticky
// overflow from the read-domain Gray pointer.
// Optional build macro: WPTR_RSYNC_EN -- when defined, g_rptr is taken raw from
// the read domain and passed through an internal 2-flop synchronizer on wclk;
// otherwise g_rptr is assumed to be synchronized already.
module wptr_handler #(
    parameter int PTR_WIDTH = 3,
    parameter int DEPTH     = 8,
    parameter int AF_LEVEL  = 6
) (
    input  logic          wclk,
    input  logic          wrst,
    wptr_handler_if.slave wif
);
    localparam logic [PTR_WIDTH:0] AF_THR = AF_LEVEL[PTR_WIDTH:0];

    if (DEPTH != (1 << PTR_WIDTH)) begin : g_depth_chk
        $error("wptr_handler: DEPTH must equal 2**PTR_WIDTH");
    end

    logic [PTR_WIDTH:0] b_wptr_q;
    logic [PTR_WIDTH:0] g_wptr_q;
    logic [PTR_WIDTH:0] level_q;
    logic               full_q;
    logic               af_q;
    logic               ovf_q;

    logic               wr_acc;
    logic [PTR_WIDTH:0] b_next;
    logic [PTR_WIDTH:0] g_next;
    logic [PTR_WIDTH:0] rs;
    logic [PTR_WIDTH:0] rb;
    logic [PTR_WIDTH:0] full_tgt;
    logic [PTR_WIDTH:0] level_next;

`ifdef WPTR_RSYNC_EN
    logic [PTR_WIDTH:0] rsync1_q;
    logic [PTR_WIDTH:0] rsync2_q;

    // Two-stage synchronizer bringing the read-domain Gray pointer onto wclk.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            rsync1_q <= '0;
            rsync2_q <= '0;
        end else begin
            rsync1_q <= wif.g_rptr;
            rsync2_q <= rsync1_q;
        end
    end

    assign rs = rsync2_q;
`else
    assign rs = wif.g_rptr;
`endif

    // Next-pointer, Gray-to-binary conversion and flag targets for this edge.
    always_comb begin
        wr_acc = wif.w_en & ~full_q;
        b_next = b_wptr_q + {{PTR_WIDTH{1'b0}}, wr_acc};
        g_next = b_next ^ (b_next >> 1);
        rb     = '0;
        // Binary bit i is the XOR of all Gray bits at or above i.
        for (int unsigned i = 0; i <= PTR_WIDTH; i++) begin
            rb[i] = ^(rs >> i);
        end
        full_tgt   = {~rs[PTR_WIDTH:PTR_WIDTH-1], rs[PTR_WIDTH-2:0]};
        level_next = b_next - rb;
    end

    // Pointer, flag and sticky-overflow registers; reset overrides everything.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            b_wptr_q <= '0;
            g_wptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            af_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            b_wptr_q <= b_next;
            g_wptr_q <= g_next;
            level_q  <= level_next;
            full_q   <= (g_next == full_tgt);
            af_q     <= (level_next >= AF_THR);
            if (wif.w_en & full_q) begin
                ovf_q <= 1'b1;
            end else if (wif.clr_ovf) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign wif.b_wptr      = b_wptr_q;
    assign wif.g_wptr      = g_wptr_q;
    assign wif.wr_level    = level_q;
    assign wif.full        = full_q;
    assign wif.almost_full = af_q;
    assign wif.overflow    = ovf_q;
endmodule

// File: tb/tb_wptr_handler.sv
// Scoreboard bench for wptr_handler (PTR_WIDTH=3, DEPTH=8, AF_LEVEL=6).
// The driver applies one directed vector per cycle and queues the expected
// post-edge outputs; a monitor pops and compares one entry after every edge.
module tb_wptr_handler;
    typedef struct packed {
        logic [3:0] b;
        logic [3:0] g;
        logic       full;
        logic       af;
        logic [3:0] lvl;
        logic       ovf;
    } vec_t;

    logic wclk;
    logic wrst;

    vec_t exp_q[$];
    int   tag_q[$];
    int   checks = 0;
    int   errors = 0;
    int   step_n = 0;

    wptr_handler_if #(.PTR_WIDTH(3)) bus ();

    wptr_handler #(
        .PTR_WIDTH (3),
        .DEPTH     (8),
        .AF_LEVEL  (6)
    ) dut (
        .wclk (wclk),
        .wrst (wrst),
        .wif  (bus)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    function automatic logic [3:0] gray4(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    // Apply one vector at the falling edge and queue the expected post-edge outputs.
    task automatic drive(input logic rst, input logic we, input logic [3:0] gr,
                         input logic clr, input logic [3:0] eb, input logic ef,
                         input logic eaf, input logic [3:0] el, input logic eovf,
                         input int tid);
        vec_t e;
        @(negedge wclk);
        wrst        = rst;
        bus.w_en    = we;
        bus.g_rptr  = gr;
        bus.clr_ovf = clr;
        e.b    = eb;
        e.g    = gray4(eb);
        e.full = ef;
        e.af   = eaf;
        e.lvl  = el;
        e.ovf  = eovf;
        step_n++;
        exp_q.push_back(e);
        tag_q.push_back(tid * 1000 + step_n);
    endtask

    // Monitor: compare DUT outputs against the oldest queued expectation.
    initial begin
        vec_t a;
        vec_t e;
        int   t;
        forever begin
            @(posedge wclk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                a = {bus.b_wptr, bus.g_wptr, bus.full, bus.almost_full,
                     bus.wr_level, bus.overflow};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL test%0d_step%0d: got b=%h g=%h full=%b af=%b lvl=%0d ovf=%b, want b=%h g=%h full=%b af=%b lvl=%0d ovf=%b",
                             t / 1000, t % 1000, a.b, a.g, a.full, a.af, a.lvl, a.ovf,
                             e.b, e.g, e.full, e.af, e.lvl, e.ovf);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // Directed stimulus.
    initial begin
        wrst        = 1'b1;
        bus.w_en    = 1'b0;
        bus.g_rptr  = '0;
        bus.clr_ovf = 1'b0;

        // 1: reset held two cycles with a write request pending
        repeat (2) drive(1, 1, 4'b1111, 0, 4'd0, 0, 0, 4'd0, 0, 1);

        // 2: eight back-to-back writes from empty
        for (int k = 1; k <= 8; k++)
            drive(0, 1, 4'b0000, 0, 4'(k), (k == 8), (k >= 6), 4'(k), 0, 2);

        // 3: write while full, then set+clear, then clear alone
        drive(0, 1, 4'b0000, 0, 4'd8, 1, 1, 4'd8, 1, 3);
        drive(0, 1, 4'b0000, 1, 4'd8, 1, 1, 4'd8, 1, 3);
        drive(0, 0, 4'b0000, 1, 4'd8, 1, 1, 4'd8, 0, 3);

        // 4: read pointer advances to binary 2
`ifdef WPTR_RSYNC_EN
        repeat (2) drive(0, 0, 4'b0011, 0, 4'd8, 1, 1, 4'd8, 0, 4);
`endif
        drive(0, 0, 4'b0011, 0, 4'd8, 0, 1, 4'd6, 0, 4);

        // 5: bring read pointer to binary 6 (level 2), then stream with read trailing by 2
`ifdef WPTR_RSYNC_EN
        repeat (2) drive(0, 0, 4'b0101, 0, 4'd8, 0, 1, 4'd6, 0, 5);
`endif
        drive(0, 0, 4'b0101, 0, 4'd8, 0, 0, 4'd2, 0, 5);
        for (int i = 1; i <= 40; i++) begin
`ifdef WPTR_RSYNC_EN
            drive(0, 1, gray4(4'((8 + i - 2) % 16)), 0, 4'((8 + i) % 16), 0, 0,
                  (i == 1) ? 4'd3 : 4'd4, 0, 5);
`else
            drive(0, 1, gray4(4'((8 + i - 2) % 16)), 0, 4'((8 + i) % 16), 0, 0,
                  4'd2, 0, 5);
`endif
        end

        // 6: settle at level 2 (b=0, read at 14), fill to level 5, reset mid-fill
`ifdef WPTR_RSYNC_EN
        drive(0, 0, 4'b1001, 0, 4'd0, 0, 0, 4'd3, 0, 6);
`else
        drive(0, 0, 4'b1001, 0, 4'd0, 0, 0, 4'd2, 0, 6);
`endif
        repeat (2) drive(0, 0, 4'b1001, 0, 4'd0, 0, 0, 4'd2, 0, 6);
        for (int k = 1; k <= 3; k++)
            drive(0, 1, 4'b1001, 0, 4'(k), 0, 0, 4'(k + 2), 0, 6);
        drive(1, 1, 4'b1001, 0, 4'd0, 0, 0, 4'd0, 0, 6);
        for (int k = 1; k <= 8; k++)
            drive(0, 1, 4'b0000, 0, 4'(k), (k == 8), (k >= 6), 4'(k), 0, 7);
        drive(0, 1, 4'b0000, 0, 4'd8, 1, 1, 4'd8, 1, 7);

        @(negedge wclk);
        bus.w_en = 1'b0;
        for (int c = 0; c < 8 && exp_q.size() != 0; c++) @(posedge wclk);
        #2;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
